// File: rtl/dial_pkg.sv
// Shared constants and helpers for the paced quadrature dial emulator.
package dial_pkg;

    localparam int unsigned PHASE_W = 2;
    localparam int unsigned DELTA_W = 8;

    // Phase index to dial pins, indexed by phase: p0=00, p1=01, p2=11, p3=10.
    localparam logic [3:0][PHASE_W-1:0] PHASE_DIAL = {2'b10, 2'b11, 2'b01, 2'b00};

    // Idle phase; the core reads dial=11 as the resting position.
    localparam logic [PHASE_W-1:0] RESET_PHASE = 2'd2;

    // Signed add clipped symmetrically to +/-(2^(width-1)-1).
    function automatic logic signed [31:0] sat_add(
        input logic signed [31:0] a,
        input logic signed [31:0] b,
        input int unsigned        width
    );
        logic signed [31:0] lim;
        logic signed [31:0] sum;
        lim = (32'sd1 <<< (width - 32'd1)) - 32'sd1;
        sum = a + b;
        if (sum > lim) begin
            sat_add = lim;
        end else if (sum < -lim) begin
            sat_add = -lim;
        end else begin
            sat_add = sum;
        end
    endfunction

endpackage

// File: rtl/dial_tick_gen.sv
// Step-rate prescaler: one-cycle registered tick every STEP_DIV clocks.
module dial_tick_gen #(
    parameter int unsigned STEP_DIV = 12000
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick
);

    localparam int unsigned CNT_W = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(STEP_DIV - 2);

    logic [CNT_W-1:0] cnt;

    // tick is raised one edge early so it is high exactly while cnt sits at terminal count
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            cnt  <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
            tick <= (cnt == CNT_PRE);
        end
    end

endmodule

// File: rtl/dial_quadrature.sv
// Spinner/dial emulator: merges held directions and relative spinner deltas
// into a saturating step backlog and emits Gray-coded phases at the tick rate.
module dial_quadrature
    import dial_pkg::*;
#(
    parameter int unsigned STEP_DIV   = 12000,
    parameter int unsigned REPEAT_DIV = 4,
    parameter int unsigned PEND_W     = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enable,
    input  logic               hold_cw,
    input  logic               hold_ccw,
    input  logic               spin_strobe,
    input  logic [DELTA_W-1:0] spin_delta,
    output logic [PHASE_W-1:0] dial,
    output logic               busy
);

    localparam int unsigned SUM_W = ((PEND_W > DELTA_W) ? PEND_W : DELTA_W) + 2;
    localparam int unsigned REP_W = (REPEAT_DIV > 2) ? $clog2(REPEAT_DIV) : 1;
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_DIV - 1);

    logic                     tick;
    logic [PHASE_W-1:0]       phase;
    logic [PHASE_W-1:0]       phase_next;
    logic signed [PEND_W-1:0] pending;
    logic signed [PEND_W-1:0] pending_next;
    logic [REP_W-1:0]         rep_cnt;
    logic [REP_W-1:0]         rep_cur;
    logic [REP_W-1:0]         rep_next;
    logic [1:0]               hold_prev;
    logic                     one_hold;
    logic                     hold_fresh;
    logic                     repeat_evt;
    logic                     pend_pos;
    logic                     pend_neg;
    logic signed [SUM_W-1:0]  add_strobe;
    logic signed [SUM_W-1:0]  add_hold;
    logic signed [SUM_W-1:0]  consume;
    logic signed [SUM_W-1:0]  sum_in;

    dial_tick_gen #(
        .STEP_DIV (STEP_DIV)
    ) u_tick_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (tick)
    );

    // Repeat pacing: a fresh single-direction hold presets the counter so the
    // first held step lands on the very next tick.
    always_comb begin
        one_hold   = hold_cw ^ hold_ccw;
        hold_fresh = one_hold && ({hold_cw, hold_ccw} != hold_prev);
        rep_cur    = hold_fresh ? REP_LAST : rep_cnt;
        repeat_evt = tick && one_hold && (rep_cur == REP_LAST);
        rep_next   = rep_cur;
        if (!one_hold) begin
            rep_next = '0;
        end else if (tick) begin
            rep_next = repeat_evt ? '0 : rep_cur + 1'b1;
        end
    end

    // Backlog update; consume is decided from the registered pending only, so
    // a strobe landing on a tick cycle waits for the next tick.
    always_comb begin
        pend_neg   = pending[PEND_W-1];
        pend_pos   = !pend_neg && (pending != '0);
        add_strobe = spin_strobe ? SUM_W'($signed(spin_delta)) : '0;
        add_hold   = '0;
        if (repeat_evt) begin
            add_hold = hold_cw ? SUM_W'(1) : '1;
        end
        consume    = '0;
        phase_next = phase;
        if (tick && pend_pos) begin
            consume    = SUM_W'(1);
            phase_next = phase + 2'd1;
        end else if (tick && pend_neg) begin
            consume    = '1;
            phase_next = phase - 2'd1;
        end
        sum_in       = SUM_W'(pending) + add_strobe + add_hold;
        pending_next = PEND_W'(sat_add(32'(sum_in), 32'(-consume), PEND_W));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase     <= RESET_PHASE;
            dial      <= PHASE_DIAL[RESET_PHASE];
            pending   <= '0;
            busy      <= 1'b0;
            rep_cnt   <= '0;
            hold_prev <= '0;
        end else if (!enable) begin
            phase     <= RESET_PHASE;
            dial      <= PHASE_DIAL[RESET_PHASE];
            pending   <= '0;
            busy      <= 1'b0;
            rep_cnt   <= '0;
            hold_prev <= '0;
        end else begin
            phase     <= phase_next;
            dial      <= PHASE_DIAL[phase_next];
            pending   <= pending_next;
            busy      <= (pending_next != '0);
            rep_cnt   <= rep_next;
            hold_prev <= {hold_cw, hold_ccw};
        end
    end

endmodule

// File: tb/tb_dial_quadrature.sv
// Bench for dial_quadrature: directed scenarios plus a randomized run against a behavioural model.
module tb_dial_quadrature;

    localparam int unsigned STEP_DIV   = 8;
    localparam int unsigned REPEAT_DIV = 4;
    localparam int unsigned PEND_W     = 8;
    localparam int          PMAX       = 127;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       enable = 1'b0;
    logic       hold_cw = 1'b0;
    logic       hold_ccw = 1'b0;
    logic       spin_strobe = 1'b0;
    logic [7:0] spin_delta = 8'd0;
    logic [1:0] dial;
    logic       busy;

    int total = 0;
    int bad = 0;

    dial_quadrature #(
        .STEP_DIV   (STEP_DIV),
        .REPEAT_DIV (REPEAT_DIV),
        .PEND_W     (PEND_W)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .hold_cw     (hold_cw),
        .hold_ccw    (hold_ccw),
        .spin_strobe (spin_strobe),
        .spin_delta  (spin_delta),
        .dial        (dial),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Behavioural model: integer backlog, phase, and ticks-since-hold-start.
    int         m_cycles = 0;
    int         m_ticks = 0;
    int         m_pend = 0;
    int         m_phase = 2;
    int         m_held = 0;
    logic [1:0] m_hold_prev = 2'b00;
    logic [1:0] m_dial = 2'b11;
    logic       m_busy = 1'b0;

    function automatic logic [1:0] dial_of(input int p);
        case (p)
            0:       return 2'b00;
            1:       return 2'b01;
            2:       return 2'b11;
            default: return 2'b10;
        endcase
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_cycles = 0; m_ticks = 0; m_pend = 0; m_phase = 2; m_held = 0;
            m_hold_prev = 2'b00; m_dial = 2'b11; m_busy = 1'b0;
        end else begin
            bit tick;
            bit one;
            int step;
            int add;
            tick = (m_cycles % STEP_DIV) == (STEP_DIV - 1);
            m_cycles++;
            if (tick) m_ticks++;
            if (!enable) begin
                m_pend = 0; m_phase = 2; m_held = 0; m_hold_prev = 2'b00;
            end else begin
                one = hold_cw ^ hold_ccw;
                if (!one || ({hold_cw, hold_ccw} != m_hold_prev)) m_held = 0;
                add = 0;
                if (one && tick) begin
                    if ((m_held % REPEAT_DIV) == 0) add = hold_cw ? 1 : -1;
                    m_held++;
                end
                m_hold_prev = {hold_cw, hold_ccw};
                step = 0;
                if (tick) step = (m_pend > 0) ? 1 : ((m_pend < 0) ? -1 : 0);
                m_phase = (m_phase + step + 4) % 4;
                m_pend = m_pend + add - step + (spin_strobe ? int'($signed(spin_delta)) : 0);
                if (m_pend > PMAX) m_pend = PMAX;
                if (m_pend < -PMAX) m_pend = -PMAX;
            end
            m_dial = dial_of(m_phase);
            m_busy = (m_pend != 0);
        end
    end

    task automatic pulse(input logic [7:0] d);
        spin_strobe = 1'b1;
        spin_delta  = d;
        @(negedge clk);
        spin_strobe = 1'b0;
        spin_delta  = 8'd0;
    endtask

    task automatic restart();
        enable = 1'b0;
        @(negedge clk);
        enable = 1'b1;
    endtask

    task automatic count_changes(input int nticks, output int n, output bit ok);
        int target;
        logic [1:0] last;
        target = m_ticks + nticks;
        last = dial;
        n = 0;
        ok = 1'b0;
        for (int i = 0; i < (nticks + 1) * STEP_DIV + 4; i++) begin
            @(negedge clk);
            if (dial !== last) n++;
            last = dial;
            if (m_ticks >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_dial_change(input int budget, output logic [1:0] v, output bit ok);
        logic [1:0] start;
        start = dial;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (dial !== start) begin
                ok = 1'b1;
                break;
            end
        end
        v = dial;
    endtask

    task automatic test_reset();
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (dial !== 2'b11) begin bad++; $display("FAIL reset_dial got=%b want=11", dial); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_idle();
        int n;
        bit ok;
        enable = 1'b1;
        for (int t = 0; t < 5; t++) begin
            count_changes(1, n, ok);
            total++;
            if (!ok || {dial, busy} !== 3'b110)
                begin bad++; $display("FAIL idle_tick%0d got=%b%b ok=%0d want=110", t, dial, busy, ok); end
        end
    endtask

    task automatic test_strobe_pos();
        logic [1:0] exp[3] = '{2'b10, 2'b00, 2'b01};
        logic [1:0] v;
        bit ok;
        restart();
        pulse(8'd3);
        for (int i = 0; i < 3; i++) begin
            wait_dial_change(3 * STEP_DIV, v, ok);
            total++;
            if (!ok || v !== exp[i]) begin bad++; $display("FAIL pos_step%0d got=%b ok=%0d want=%b", i, v, ok, exp[i]); end
        end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL pos_busy got=%b want=0", busy); end
    endtask

    task automatic test_strobe_neg();
        logic [1:0] exp[5] = '{2'b01, 2'b00, 2'b10, 2'b11, 2'b01};
        logic [1:0] v;
        bit ok;
        restart();
        pulse(8'hFE);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) pulse(8'hFD);
            wait_dial_change(3 * STEP_DIV, v, ok);
            total++;
            if (!ok || v !== exp[i]) begin bad++; $display("FAIL neg_step%0d got=%b ok=%0d want=%b", i, v, ok, exp[i]); end
        end
        total++;
        if (busy !== 1'b0 || dial !== m_dial)
            begin bad++; $display("FAIL neg_end got=%b/%b want=0/%b", busy, dial, m_dial); end
    endtask

    task automatic test_hold();
        int c1;
        int c2;
        bit ok1;
        bit ok2;
        restart();
        hold_cw = 1'b1;
        count_changes(9, c1, ok1);
        hold_cw = 1'b0;
        count_changes(3, c2, ok2);
        total++;
        if (!ok1 || c1 !== 2) begin bad++; $display("FAIL hold_window got=%0d ok=%0d want=2", c1, ok1); end
        total++;
        if (!ok2 || c1 + c2 !== 3) begin bad++; $display("FAIL hold_total got=%0d want=3", c1 + c2); end
        total++;
        if (dial !== 2'b01 || busy !== 1'b0) begin bad++; $display("FAIL hold_end got=%b/%b want=01/0", dial, busy); end
        restart();
        hold_cw = 1'b1;
        hold_ccw = 1'b1;
        count_changes(9, c1, ok1);
        hold_cw = 1'b0;
        hold_ccw = 1'b0;
        total++;
        if (!ok1 || c1 !== 0 || busy !== 1'b0)
            begin bad++; $display("FAIL hold_both got=%0d busy=%b want=0/0", c1, busy); end
    endtask

    task automatic test_saturate();
        int n;
        bit done;
        logic [1:0] last;
        restart();
        pulse(8'd127);
        pulse(8'd50);
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL sat_busy got=%b want=1", busy); end
        n = 0;
        done = 1'b0;
        last = dial;
        for (int i = 0; i < 140 * STEP_DIV; i++) begin
            @(negedge clk);
            if (dial !== last) n++;
            last = dial;
            if (busy === 1'b0) begin
                done = 1'b1;
                break;
            end
        end
        total++;
        if (!done || n !== 127) begin bad++; $display("FAIL sat_steps got=%0d done=%0d want=127", n, done); end
        total++;
        if (dial !== 2'b01) begin bad++; $display("FAIL sat_dial got=%b want=01", dial); end
    endtask

    task automatic test_disable();
        int n;
        bit ok;
        restart();
        pulse(8'd10);
        count_changes(3, n, ok);
        enable = 1'b0;
        @(negedge clk);
        total++;
        if (dial !== 2'b11 || busy !== 1'b0) begin bad++; $display("FAIL dis_clear got=%b/%b want=11/0", dial, busy); end
        enable = 1'b1;
        count_changes(5, n, ok);
        total++;
        if (!ok || n !== 0 || dial !== 2'b11 || busy !== 1'b0)
            begin bad++; $display("FAIL dis_resume got=%0d steps dial=%b busy=%b want=0/11/0", n, dial, busy); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 4000; i++) begin
            enable = ($urandom_range(0, 299) != 0);
            if ((i % 40) == 0) {hold_cw, hold_ccw} = 2'($urandom_range(0, 3));
            spin_strobe = ($urandom_range(0, 11) == 0);
            spin_delta = 8'($urandom);
            @(negedge clk);
            total++;
            if (dial !== m_dial || busy !== m_busy)
                begin bad++; $display("FAIL rand_cyc%0d got=%b/%b want=%b/%b", i, dial, busy, m_dial, m_busy); end
        end
        spin_strobe = 1'b0;
        hold_cw = 1'b0;
        hold_ccw = 1'b0;
        enable = 1'b1;
    endtask

    initial begin
        test_reset();
        test_idle();
        test_strobe_pos();
        test_strobe_neg();
        test_hold();
        test_saturate();
        test_disable();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dial_quadrature.md
Name: dial_quadrature

Overview:
- Spinner/dial emulator feeding the two-bit dial field of the player input word on the Squash variant.
- Replaces the combinational up/down-to-dial mapping with a paced quadrature generator.
- Accepts digital hold (joystick up/down) and signed relative deltas from a USB spinner; emits a Gray-coded phase pair at a bounded step rate.
- One instance per player, sitting between joystick mapping and the game core input port.

Parameters:
- STEP_DIV, 12000, clk cycles per step tick (1 ms at 12 MHz); must be >= 2.
- REPEAT_DIV, 4, step ticks between auto-generated steps while a direction is held.
- PEND_W, 8, width of the signed pending-step accumulator; saturates at ±(2^(PEND_W-1)-1).

Ports:
- clk  in  1  system clock (clk_sys domain).
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  1 = spinner mode active; 0 = dial idle, accumulator cleared.
- hold_cw  in  1  held direction, clockwise (maps from joystick down).
- hold_ccw  in  1  held direction, counter-clockwise (maps from joystick up).
- spin_strobe  in  1  single-cycle valid for spin_delta.
- spin_delta  in  8  signed relative movement; positive = clockwise.
- dial  out  2  quadrature phase pair, active high, to the core input word (core inverts).
- busy  out  1  pending accumulator non-zero.

Behaviour:
- Phase index p (2 bits) encodes dial: p0=00, p1=01, p2=11, p3=10.
  - Clockwise step: p+1 mod 4.
  - Counter-clockwise step: p-1 mod 4.
  - Wrap 3->0 and 0->3 is legal and required.
- Reset (async assert, sync release): p=2 (dial=11), pending=0, prescaler=0, repeat counter=0, busy=0.
- Prescaler counts 0..STEP_DIV-1; tick asserts for one cycle at terminal count and the counter wraps to 0.
- Accumulator update, every cycle: pending_next = sat(pending + add_strobe + add_hold - consume).
  - add_strobe = sign-extended spin_delta when spin_strobe, else 0.
  - add_hold = +1 on a repeat event with hold_cw only; -1 on a repeat event with hold_ccw only; 0 otherwise, including when both are held.
  - consume = sign(pending) on a tick, else 0.
  - All terms are summed in PEND_W+2 bits before saturation; no intermediate wrap.
- Repeat counter:
  - Advances on ticks while exactly one hold input is asserted; clears when neither or both are asserted.
  - A repeat event fires on the tick where it reaches REPEAT_DIV-1; the counter then wraps to 0.
  - The first held step is generated immediately, on the first tick after the hold asserts, so the counter is preset to REPEAT_DIV-1 on hold rising.
- Step issue: on a tick with pending>0, p advances CW; with pending<0, p advances CCW. At most one step per tick.
- Latency:
  - A dial change appears on the cycle after the tick edge that consumes the step, i.e. dial is registered.
  - A strobe arriving in the same cycle as a tick does not contribute to that tick's consume decision; it is counted on the next tick.
- Saturation: deltas beyond capacity are discarded. Pending stays at ±max and is never reversed by overflow.
- enable=0: pending, repeat counter and busy are forced to 0 and p is forced to 2 (dial=11, the core's idle value). The prescaler keeps running.
- enable rising: normal operation resumes from p=2 with no spurious step.
- busy = (pending != 0), registered together with pending.

Decomposition:
- Package dial_pkg:
  - phase-to-dial lookup constant (00,01,11,10);
  - reset phase constant (2);
  - saturating-add function, parameterised by width.
- Sub-module dial_tick_gen: prescaler (STEP_DIV) producing the single-cycle tick, with reset_n.
- Accumulator, repeat logic and phase register stay in dial_quadrature.

Test Plan:
- Reset, then enable=1 with no input for 5 ticks -> dial=11 throughout, busy=0.
- One strobe with spin_delta=+3 -> over the next 3 ticks dial goes 10, 00, 01; busy falls after the third tick.
- One strobe with spin_delta=-2 from p=2 -> dial goes 01, then 00; the CCW wrap is checked separately by a -3 from p=0 giving 10, 11, 01.
- hold_cw held for 9 ticks with REPEAT_DIV=4 -> steps on ticks 1, 5 and 9 (3 steps); hold_cw and hold_ccw both held -> no steps.
- Strobe +127, then +50 (PEND_W=8) -> pending saturates at 127; exactly 127 CW steps follow and busy then drops.
- pending=+10 mid-stream, then enable=0 for one cycle -> dial=11 and busy=0 next cycle; after re-enable, no further steps occur without new input.
